// File: rtl/bp_fe_fetch_queue_if.sv
// Fetch-queue handshake bundle: fetch credits, icache responses, replay and
// per-instruction dequeue toward the frontend consumer.
interface bp_fe_fetch_queue_if #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32,
   parameter int fetch_width_p = 2
);
   logic                                     fetch_v_i;
   logic                                     fetch_ready_o;
   logic                                     resp_v_i;
   logic [vaddr_width_p-1:0]                 resp_pc_i;
   logic [fetch_width_p*instr_width_p-1:0]   resp_data_i;
   logic                                     resp_miss_i;
   logic                                     resp_access_fault_i;
   logic                                     resp_page_fault_i;
   logic                                     poison_i;
   logic                                     replay_v_o;
   logic [vaddr_width_p-1:0]                 replay_pc_o;
   logic                                     fe_v_o;
   logic [vaddr_width_p-1:0]                 fe_pc_o;
   logic [instr_width_p-1:0]                 fe_instr_o;
   logic                                     fe_access_fault_o;
   logic                                     fe_page_fault_o;
   logic                                     fe_yumi_i;

   modport master (
      output fetch_v_i, resp_v_i, resp_pc_i, resp_data_i, resp_miss_i,
             resp_access_fault_i, resp_page_fault_i, poison_i, fe_yumi_i,
      input  fetch_ready_o, replay_v_o, replay_pc_o, fe_v_o, fe_pc_o,
             fe_instr_o, fe_access_fault_o, fe_page_fault_o
   );

   modport slave (
      input  fetch_v_i, resp_v_i, resp_pc_i, resp_data_i, resp_miss_i,
             resp_access_fault_i, resp_page_fault_i, poison_i, fe_yumi_i,
      output fetch_ready_o, replay_v_o, replay_pc_o, fe_v_o, fe_pc_o,
             fe_instr_o, fe_access_fault_o, fe_page_fault_o
   );
endinterface

// File: rtl/bp_fe_fetch_queue.sv
// Credit-based fetch queue: buffers icache fetch blocks, replays misses and
// hands instructions one lane at a time to the frontend consumer.
module bp_fe_fetch_queue #(
   parameter int els_p         = 4,
   parameter int fetch_width_p = 2,
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   bp_fe_fetch_queue_if.slave   fq
);
   localparam int ptr_w  = $clog2(els_p);
   localparam int cnt_w  = $clog2(els_p + 1);
   localparam int lane_w = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
   localparam int n_w    = $clog2(fetch_width_p + 1);
   localparam int data_w = fetch_width_p * instr_width_p;
   localparam logic [cnt_w-1:0] els_lp = cnt_w'(els_p);

   logic [vaddr_width_p-1:0] pc_mem    [els_p];
   logic [data_w-1:0]        data_mem  [els_p];
   logic [1:0]               fault_mem [els_p];
   logic [n_w-1:0]           n_mem     [els_p];

   logic [cnt_w-1:0]         outstanding_r, occupancy_r, credits;
   logic [ptr_w-1:0]         head_r, tail_r;
   logic [lane_w-1:0]        k_r;
   logic                     replay_v_r;
   logic [vaddr_width_p-1:0] replay_pc_r;

   logic                     fetch_acc, resp_acc, replay_hit, wr, yumi_acc, pop, last_lane;
   logic                     resp_fault;
   logic [lane_w-1:0]        resp_lane, head_lane, lane_idx;
   logic [n_w-1:0]           resp_n, head_n;
   logic [vaddr_width_p-1:0] head_pc;
   logic [data_w-1:0]        head_data;
   logic [1:0]               head_fault;
   logic                     fe_v;

   assign credits    = els_lp - outstanding_r - occupancy_r;
   assign fe_v       = (occupancy_r != '0);
   assign resp_fault = fq.resp_access_fault_i | fq.resp_page_fault_i;

   // A fetch in the poison cycle is always counted: it belongs to the new stream.
   assign fetch_acc  = fq.fetch_v_i & ((credits != '0) | fq.poison_i);
   assign resp_acc   = fq.resp_v_i & ~fq.poison_i;
   assign replay_hit = resp_acc & fq.resp_miss_i & ~resp_fault;
   assign wr         = resp_acc & ~replay_hit;
   assign yumi_acc   = fq.fe_yumi_i & fe_v & ~fq.poison_i;
   assign pop        = yumi_acc & last_lane;

   always_comb begin
      resp_lane = '0;
      if (fetch_width_p > 1) resp_lane = fq.resp_pc_i[lane_w+1:2];
      resp_n = resp_fault ? n_w'(1) : (n_w'(fetch_width_p) - n_w'(resp_lane));
   end

   always_comb begin
      head_pc    = pc_mem[head_r];
      head_data  = data_mem[head_r];
      head_fault = fault_mem[head_r];
      head_n     = n_mem[head_r];
      head_lane  = '0;
      if (fetch_width_p > 1) head_lane = head_pc[lane_w+1:2];
      lane_idx   = (fetch_width_p > 1) ? (head_lane + k_r) : '0;
      last_lane  = ((n_w'(k_r) + n_w'(1)) == head_n);
   end

   assign fq.fetch_ready_o     = (credits != '0);
   assign fq.fe_v_o            = fe_v;
   assign fq.fe_pc_o           = head_pc + vaddr_width_p'({k_r, 2'b00});
   assign fq.fe_instr_o        = head_data[lane_idx*instr_width_p +: instr_width_p];
   assign fq.fe_access_fault_o = fe_v & head_fault[0];
   assign fq.fe_page_fault_o   = fe_v & head_fault[1];
   assign fq.replay_v_o        = replay_v_r;
   assign fq.replay_pc_o       = replay_pc_r;

   always_ff @(posedge clk_i) begin
      if (wr & ~reset_i) begin
         pc_mem[tail_r]    <= fq.resp_pc_i;
         data_mem[tail_r]  <= fq.resp_data_i;
         fault_mem[tail_r] <= {fq.resp_page_fault_i, fq.resp_access_fault_i};
         n_mem[tail_r]     <= resp_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         outstanding_r <= '0;
         occupancy_r   <= '0;
         head_r        <= '0;
         tail_r        <= '0;
         k_r           <= '0;
         replay_v_r    <= 1'b0;
         replay_pc_r   <= '0;
      end else begin
         replay_v_r <= replay_hit;
         if (replay_hit) replay_pc_r <= fq.resp_pc_i;
         if (fq.poison_i) begin
            outstanding_r <= cnt_w'(fetch_acc);
            occupancy_r   <= '0;
            k_r           <= '0;
            head_r        <= tail_r;
         end else begin
            outstanding_r <= outstanding_r + cnt_w'(fetch_acc) - cnt_w'(resp_acc);
            occupancy_r   <= occupancy_r + cnt_w'(wr) - cnt_w'(pop);
            if (wr) tail_r <= tail_r + 1'b1;
            if (pop) begin
               head_r <= head_r + 1'b1;
               k_r    <= '0;
            end else if (yumi_acc) begin
               k_r <= k_r + 1'b1;
            end
         end
      end
   end
endmodule
